// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver with a scancode FIFO, exposed on the I/O bus.
// DATA is at 0x4000 and STATUS (count plus W1C error flags) is at 0x4004.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] data_input,
    output logic [31:0] data_output,
    output logic        key_valid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2, fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_acc;
    logic [TW-1:0] idle_cnt;
    logic          push_q, perr_q, ferr_q;
    logic [7:0]    push_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, perr, ferr;
    logic          addr_data, addr_stat, pop, flush, full, do_push, ovf_set;
    logic [31:0]   count_ext;
    logic [2:0]    count_disp;
    logic          unused_bits;

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    // Frame receiver; par_acc folds in the parity bit so a good frame leaves it at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            idle_cnt  <= '0;
            push_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            push_byte <= '0;
        end else begin
            push_q <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        par_acc <= par_acc ^ dat_s2;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_acc <= par_acc ^ dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        push_q    <= dat_s2 & par_acc;
                        push_byte <= shreg;
                        perr_q    <= ~par_acc;
                        ferr_q    <= ~dat_s2;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt <= '0;
                    ferr_q   <= 1'b1;
                    state    <= IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign addr_data = (address == 32'h0000_4000);
    assign addr_stat = (address == 32'h0000_4004);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign key_valid = (count != '0);
    assign pop       = read_enable & addr_data & key_valid;
    assign flush     = write_enable & addr_data & data_input[0];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push   = push_q & (~full | pop) & ~flush;
    assign ovf_set   = push_q & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_push && !pop) count <= count + 1'b1;
                else if (!do_push && pop) count <= count - 1'b1;
            end
            ovf  <= (ovf  & ~(write_enable & addr_stat & data_input[3])) | ovf_set;
            perr <= (perr & ~(write_enable & addr_stat & data_input[4])) | perr_q;
            ferr <= (ferr & ~(write_enable & addr_stat & data_input[5])) | ferr_q;
        end
    end

    assign count_ext  = 32'(count);
    assign count_disp = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

    always_comb begin
        data_output = '0;
        if (addr_data && key_valid) data_output = {23'd0, 1'b1, mem[rd_ptr]};
        else if (addr_stat) data_output = {26'd0, ferr, perr, ovf, count_disp};
    end

    assign unused_bits = ^{data_input[31:6], data_input[2:1]};
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Randomized PS/2 frame stimulus against a queue-based model of the keyboard controller.
// A monitor checks every DATA read against the expected scancode queue.
module tb_ps2_keyboard_ctrl;
    localparam int FD = 4;
    localparam int TO = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [31:0] address = 32'h0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] data_input = 32'h0;
    logic [31:0] data_output;
    logic        key_valid;

    ps2_keyboard_ctrl #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .address(address), .write_enable(write_enable), .read_enable(read_enable),
        .data_input(data_input), .data_output(data_output), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    bit m_ov = 0, m_pe = 0, m_fe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every DATA read strobe must present the model queue head (or 0 when empty).
    initial begin
        logic [31:0] req;
        forever begin
            @(negedge clk);
            #2;
            if (read_enable && address == 32'h4000 && !rst) begin
                req = 32'h0;
                if (exp_q.size() > 0) req = {23'd0, 1'b1, exp_q.pop_front()};
                check("data_read", data_output, req);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit sbad,
                              input int nbits, input bit rd_at_push);
        logic [10:0] b;
        b = {~sbad, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); PS2_DAT = b[i];
            repeat (2) @(negedge clk);
            PS2_CLK = 1'b0;
            if (rd_at_push && i == 10) begin
                repeat (3) @(negedge clk);
                address = 32'h4000; read_enable = 1'b1;
                @(negedge clk); read_enable = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            PS2_CLK = 1'b1;
            repeat (3) @(negedge clk);
        end
        PS2_DAT = 1'b1;
        if (nbits == 11) begin
            if (pflip) m_pe = 1;
            if (sbad) m_fe = 1;
            if (!pflip && !sbad) begin
                if (exp_q.size() < FD) exp_q.push_back(d);
                else m_ov = 1;
            end
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_input = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; data_input = 32'h0;
        if (a == 32'h4000 && d[0]) exp_q.delete();
        if (a == 32'h4004) begin
            if (d[3]) m_ov = 0;
            if (d[4]) m_pe = 0;
            if (d[5]) m_fe = 0;
        end
    endtask

    task automatic bus_read_data();
        @(negedge clk);
        address = 32'h4000; read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    task automatic check_status(input string name);
        logic [2:0] c;
        @(negedge clk);
        address = 32'h4004;
        #2;
        c = 3'(exp_q.size());
        check(name, data_output, {26'd0, m_fe, m_pe, m_ov, c});
        check({name, "_kv"}, {31'd0, key_valid}, {31'd0, exp_q.size() > 0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        @(negedge clk);
        address = 32'h4000; #2;
        check("reset_data", data_output, 32'h0);
        check_status("reset_status");
        rst = 1'b0;

        send_frame(8'h1C, 0, 0, 11, 0);
        check_status("good_1c_status");
        bus_read_data();
        check_status("after_read_status");

        send_frame(8'h1C, 1, 0, 11, 0);
        check_status("parity_err_status");
        bus_write(32'h4004, 32'h10);
        check_status("parity_clear_status");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 11, 0);
        check_status("overflow_status");
        for (int i = 0; i < 5; i++) bus_read_data();
        bus_write(32'h4004, 32'h08);

        send_frame(8'h1C, 0, 0, 5, 0);
        repeat (TO + 5) @(negedge clk);
        m_fe = 1;
        check_status("timeout_status");
        send_frame(8'h1C, 0, 0, 11, 0);
        bus_read_data();
        bus_write(32'h4004, 32'h20);

        send_frame(8'h01, 0, 0, 11, 0);
        send_frame(8'h02, 0, 0, 11, 1);
        check_status("coincident_status");
        bus_read_data();

        send_frame(8'h33, 0, 0, 6, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        exp_q.delete(); m_ov = 0; m_pe = 0; m_fe = 0;
        send_frame(8'h5A, 0, 0, 11, 0);
        check_status("post_reset_status");
        bus_read_data();

        send_frame(8'h44, 0, 1, 11, 0);
        check_status("stop_err_status");
        send_frame(8'h45, 0, 0, 11, 0);
        send_frame(8'h46, 0, 0, 11, 0);
        bus_write(32'h4000, 32'h1);
        check_status("flush_status");
        bus_write(32'h4004, 32'h38);

        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0,
                       $urandom_range(0, 6) == 0, 11, 0);
            for (int r = $urandom_range(0, 2); r > 0; r--) bus_read_data();
            if ($urandom_range(0, 2) == 0) check_status("rand_status");
            if ($urandom_range(0, 5) == 0) bus_write(32'h4004, 32'h38);
        end
        while (exp_q.size() > 0) bus_read_data();
        bus_read_data();
        check_status("final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
